// File: rtl/buf_tag_lookup.sv
// rtl/buf_tag_lookup.sv - 4-entry fully associative tag store in front of the LFU replacement unit
// Hits and invalid-entry fills answer from CMP; eviction misses ask the replacement unit for a victim.
module buf_tag_lookup #(
  parameter int TAG_W    = 8,
  parameter bit FILL_INV = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_req,
  input  logic [TAG_W-1:0] acc_tag,
  input  logic             flush,
  output logic             acc_rdy,
  output logic             acc_ack,
  output logic             acc_hit,
  output logic [1:0]       acc_idx,
  output logic             new_buf_req,
  output logic [1:0]       ref_buf_numbr,
  output logic             ref_vld,
  input  logic [1:0]       buf_num_replc
);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_REQ, S_WAIT} state_t;

  state_t           state, state_d;
  logic [TAG_W-1:0] tag_q [4];
  logic [3:0]       valid_q, valid_d;
  logic [TAG_W-1:0] cap_tag, cap_tag_d;

  logic             acc_rdy_d, acc_ack_d, acc_hit_d, new_buf_req_d, ref_vld_d;
  logic [1:0]       acc_idx_d, ref_buf_numbr_d;
  logic             tag_we;
  logic [1:0]       tag_widx;

  logic             hit, inv_any;
  logic [1:0]       hit_idx, inv_idx;

  // Descending scan so the lowest matching / invalid index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 2'd0;
    inv_any = 1'b0;
    inv_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (valid_q[i] && (tag_q[i] == cap_tag)) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
      if (!valid_q[i]) begin
        inv_any = 1'b1;
        inv_idx = 2'(i);
      end
    end
  end

  always_comb begin
    state_d         = state;
    cap_tag_d       = cap_tag;
    valid_d         = valid_q;
    acc_rdy_d       = acc_rdy;
    acc_ack_d       = 1'b0;
    acc_hit_d       = acc_hit;
    acc_idx_d       = acc_idx;
    new_buf_req_d   = 1'b0;
    ref_buf_numbr_d = ref_buf_numbr;
    ref_vld_d       = 1'b0;
    tag_we          = 1'b0;
    tag_widx        = 2'd0;

    case (state)
      S_IDLE: begin
        if (flush) valid_d = 4'b0000;
        if (acc_req) begin
          cap_tag_d = acc_tag;
          acc_rdy_d = 1'b0;
          state_d   = S_CMP;
        end
      end
      S_CMP: begin
        if (hit) begin
          acc_ack_d       = 1'b1;
          acc_hit_d       = 1'b1;
          acc_idx_d       = hit_idx;
          ref_buf_numbr_d = hit_idx;
          ref_vld_d       = 1'b1;
          acc_rdy_d       = 1'b1;
          state_d         = S_IDLE;
        end else if (inv_any && (FILL_INV || (valid_q == 4'b0000))) begin
          tag_we            = 1'b1;
          tag_widx          = inv_idx;
          valid_d[inv_idx]  = 1'b1;
          acc_ack_d         = 1'b1;
          acc_hit_d         = 1'b0;
          acc_idx_d         = inv_idx;
          ref_buf_numbr_d   = inv_idx;
          ref_vld_d         = 1'b1;
          acc_rdy_d         = 1'b1;
          state_d           = S_IDLE;
        end else begin
          new_buf_req_d = 1'b1;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tag_we                  = 1'b1;
        tag_widx                = buf_num_replc;
        valid_d[buf_num_replc]  = 1'b1;
        acc_ack_d               = 1'b1;
        acc_hit_d               = 1'b0;
        acc_idx_d               = buf_num_replc;
        ref_buf_numbr_d         = buf_num_replc;
        ref_vld_d               = 1'b1;
        acc_rdy_d               = 1'b1;
        state_d                 = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      valid_q       <= 4'b0000;
      cap_tag       <= '0;
      acc_rdy       <= 1'b1;
      acc_ack       <= 1'b0;
      acc_hit       <= 1'b0;
      acc_idx       <= 2'd0;
      new_buf_req   <= 1'b0;
      ref_buf_numbr <= 2'd0;
      ref_vld       <= 1'b0;
    end else begin
      state         <= state_d;
      valid_q       <= valid_d;
      cap_tag       <= cap_tag_d;
      acc_rdy       <= acc_rdy_d;
      acc_ack       <= acc_ack_d;
      acc_hit       <= acc_hit_d;
      acc_idx       <= acc_idx_d;
      new_buf_req   <= new_buf_req_d;
      ref_buf_numbr <= ref_buf_numbr_d;
      ref_vld       <= ref_vld_d;
    end
  end

  // Tag contents need no reset; the write enable is already gated off while rst holds state in IDLE.
  always_ff @(posedge clk) begin
    if (tag_we) tag_q[tag_widx] <= cap_tag;
  end

  a_replc_known: assert property (@(posedge clk) disable iff (rst)
    (state == S_WAIT) |-> !$isunknown(buf_num_replc));

endmodule

// File: tb/tb_buf_tag_lookup.sv
// tb/tb_buf_tag_lookup.sv - scoreboard bench for buf_tag_lookup with a behavioural tag-store model
module tb_buf_tag_lookup;
  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             acc_req = 1'b0;
  logic [TAG_W-1:0] acc_tag = '0;
  logic             flush = 1'b0;
  logic             acc_rdy, acc_ack, acc_hit, new_buf_req, ref_vld;
  logic [1:0]       acc_idx, ref_buf_numbr;
  logic [1:0]       buf_num_replc = 2'd0;

  buf_tag_lookup #(.TAG_W(TAG_W), .FILL_INV(1'b1)) dut (
    .clk(clk), .rst(rst), .acc_req(acc_req), .acc_tag(acc_tag), .flush(flush),
    .acc_rdy(acc_rdy), .acc_ack(acc_ack), .acc_hit(acc_hit), .acc_idx(acc_idx),
    .new_buf_req(new_buf_req), .ref_buf_numbr(ref_buf_numbr), .ref_vld(ref_vld),
    .buf_num_replc(buf_num_replc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       hit;
    logic [1:0] idx;
    bit         evict;
    int         acc_cyc;
  } exp_t;

  exp_t             sb[$];
  exp_t             mon_e;
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               nbr_cnt = 0;
  bit               prev_nbr = 1'b0;
  logic [1:0]       victim = 2'd0;
  logic [TAG_W-1:0] m_tag [4];
  bit               m_val [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Replacement unit: garbage except in the cycle after it sampled new_buf_req.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (prev_nbr) buf_num_replc = victim;
      else buf_num_replc = 2'($urandom);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        nbr_cnt  = 0;
        prev_nbr = 1'b0;
      end else begin
        if (new_buf_req) begin
          check("nbr_one_cycle", {31'd0, prev_nbr}, 32'd0);
          nbr_cnt++;
        end
        prev_nbr = new_buf_req;
        if (acc_ack) begin
          check("ack_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
          if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check("acc_hit", {31'd0, acc_hit}, {31'd0, mon_e.hit});
            check("acc_idx", {30'd0, acc_idx}, {30'd0, mon_e.idx});
            check("ref_vld", {31'd0, ref_vld}, 32'd1);
            check("ref_buf_numbr", {30'd0, ref_buf_numbr}, {30'd0, mon_e.idx});
            check("acc_rdy_at_ack", {31'd0, acc_rdy}, 32'd1);
            check("ack_latency", cyc - mon_e.acc_cyc, mon_e.evict ? 32'd3 : 32'd1);
            check("nbr_count", nbr_cnt, mon_e.evict ? 32'd1 : 32'd0);
            nbr_cnt = 0;
          end
        end else begin
          if (ref_vld) check("ref_vld_without_ack", {31'd0, ref_vld}, 32'd0);
        end
      end
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_val[i] = 1'b0;
  endtask

  task automatic access(input logic [TAG_W-1:0] t, input bit fl, input logic [1:0] vic, input bit noise);
    exp_t e;
    bit   found;
    int   n;
    n = 0;
    @(negedge clk);
    while (!acc_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rdy_wait", {31'd0, acc_rdy}, 32'd1);
    if (!acc_rdy) return;
    if (fl) model_clear();
    e.hit = 1'b0; e.idx = 2'd0; e.evict = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4; i++)
      if (!found && m_val[i] && m_tag[i] == t) begin
        found = 1'b1; e.hit = 1'b1; e.idx = 2'(i);
      end
    if (!found) begin
      for (int i = 0; i < 4; i++)
        if (!found && !m_val[i]) begin
          found = 1'b1; e.idx = 2'(i);
        end
      if (!found) begin
        e.evict = 1'b1; e.idx = vic;
      end
      m_tag[e.idx] = t;
      m_val[e.idx] = 1'b1;
    end
    e.acc_cyc = cyc + 1;
    victim  = vic;
    acc_req = 1'b1;
    acc_tag = t;
    flush   = fl;
    sb.push_back(e);
    @(negedge clk);
    acc_req = 1'b0;
    flush   = 1'b0;
    if (noise) begin
      // Busy-time request and flush; both must be ignored.
      acc_req = 1'b1;
      flush   = 1'b1;
      acc_tag = 8'($urandom);
      @(negedge clk);
      acc_req = 1'b0;
      flush   = 1'b0;
    end
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    #1;
    check("rst_acc_rdy", {31'd0, acc_rdy}, 32'd1);
    check("rst_acc_ack", {31'd0, acc_ack}, 32'd0);
    check("rst_new_buf_req", {31'd0, new_buf_req}, 32'd0);
    check("rst_ref_vld", {31'd0, ref_vld}, 32'd0);
    check("rst_ref_buf_numbr", {30'd0, ref_buf_numbr}, 32'd0);
    check("rst_acc_idx", {30'd0, acc_idx}, 32'd0);
    model_clear();
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_rst();

    access(8'h11, 1'b0, 2'd0, 1'b0);
    access(8'h22, 1'b0, 2'd0, 1'b0);
    access(8'h33, 1'b0, 2'd0, 1'b0);
    access(8'h44, 1'b0, 2'd0, 1'b0);
    access(8'h33, 1'b0, 2'd0, 1'b0);
    access(8'h55, 1'b0, 2'd1, 1'b0);
    access(8'h22, 1'b0, 2'd3, 1'b0);
    access(8'h55, 1'b0, 2'd0, 1'b1);
    access(8'h44, 1'b1, 2'd0, 1'b0);
    access(8'h11, 1'b0, 2'd0, 1'b0);
    access(8'h22, 1'b0, 2'd0, 1'b0);
    access(8'h33, 1'b0, 2'd0, 1'b0);

    // Eviction aborted by reset while waiting for the victim.
    n = 0;
    @(negedge clk);
    while (!acc_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    victim  = 2'd2;
    acc_req = 1'b1;
    acc_tag = 8'h66;
    @(negedge clk);
    acc_req = 1'b0;
    n = 0;
    while (!new_buf_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("abort_nbr_seen", {31'd0, new_buf_req}, 32'd1);
    @(posedge clk);
    pulse_rst();
    repeat (5) @(negedge clk);
    check("abort_rdy_after", {31'd0, acc_rdy}, 32'd1);
    access(8'h55, 1'b0, 2'd0, 1'b0);

    for (int k = 0; k < 150; k++)
      access(8'h10 + 8'($urandom_range(0, 5)), ($urandom_range(0, 15) == 0),
             2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("sb_drained", sb.size(), 32'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/buf_tag_lookup.md
Name: buf_tag_lookup

Overview:
- 4-entry fully associative tag store that sits in front of the LFU replacement unit (lfu).
- Accepts access requests carrying a tag and resolves each as a hit, a fill into an invalid entry, or an eviction fill.
- Drives ref_buf_numbr / new_buf_req into the replacement unit and consumes its buf_num_replc to choose the victim.
- Acts as the initiator side of the replacement-unit interface.

Parameters:
- TAG_W, 8, width of stored and requested tags.
- FILL_INV, 1, 1 = a miss fills the lowest-index invalid entry before consulting the replacement unit; 0 = every miss with any entry valid consults the replacement unit (invalid entries are still filled first only when all four are invalid).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- acc_req  in  1  access request; accepted at a rising edge where acc_req=1 and acc_rdy=1.
- acc_tag  in  TAG_W  tag of the request; sampled with acc_req.
- flush  in  1  clear all valid bits; honoured only when acc_rdy=1, ignored otherwise.
- acc_rdy  out  1  registered; 1 when in IDLE.
- acc_ack  out  1  registered one-cycle pulse; response valid.
- acc_hit  out  1  with acc_ack: 1 = hit, 0 = miss/filled.
- acc_idx  out  2  with acc_ack: entry index hit or filled.
- new_buf_req  out  1  registered one-cycle pulse to replacement unit.
- ref_buf_numbr  out  2  registered; index of the last referenced entry, held between references.
- ref_vld  out  1  registered one-cycle pulse, coincident with acc_ack.
- buf_num_replc  in  2  victim index from replacement unit; valid from the cycle after the edge that sampled new_buf_req=1.

Behaviour:
- Storage: tag[0..3] (TAG_W each), valid[0..3].
- Reset (async): state=IDLE, valid=0, acc_rdy=1, acc_ack=0, acc_hit=0, acc_idx=0, new_buf_req=0, ref_buf_numbr=0, ref_vld=0. Tags are don't-care.
- Reset mid-operation aborts the transaction: no ack, no tag write.
- FSM states: IDLE, CMP, REQ, WAIT.
- IDLE, acc_req accepted: capture acc_tag, go CMP, acc_rdy<=0.
- CMP: compare the captured tag with every valid entry.
  - Hit at i: acc_ack<=1, acc_hit<=1, acc_idx<=i, ref_buf_numbr<=i, ref_vld<=1, go IDLE.
  - Miss with an invalid entry (per FILL_INV): write the lowest invalid index j (tag, valid=1), ack with acc_hit=0, acc_idx=j, ref_buf_numbr<=j, ref_vld<=1, go IDLE.
  - Miss otherwise: new_buf_req<=1, go REQ.
- REQ: new_buf_req<=0, go WAIT.
- WAIT: sample buf_num_replc=v, write tag[v], valid[v]=1, ack acc_hit=0, acc_idx=v, ref_buf_numbr<=v, ref_vld<=1, go IDLE.
- acc_rdy<=1 on every transition into IDLE, so back-to-back requests are allowed in the ack cycle.
- Latency from the accepting edge to acc_ack high: hit/invalid-fill = 1 cycle later (ack visible in the 2nd cycle after request); eviction = 3 cycles later.
- Exactly one ack per accepted request. acc_ack, ref_vld and new_buf_req never last more than 1 cycle.
- Multiple matching entries cannot occur (fill only on miss). If they do, the lowest index wins.
- Flush: at an edge with flush=1 and acc_rdy=1, valid<=0. A simultaneous accepted acc_req is looked up against the flushed (all-invalid) store and fills entry 0.
- acc_req while acc_rdy=0 is ignored, not queued.
- buf_num_replc is ignored outside WAIT. X on buf_num_replc in WAIT is a protocol violation; assertion flags it.

Test Plan:
- Reset: assert rst mid-cycle -> immediately acc_rdy=1, acc_ack=0, new_buf_req=0, ref_vld=0, ref_buf_numbr=0.
- Cold fills: requests 0x11, 0x22, 0x33, 0x44 back-to-back -> acks acc_hit=0 with acc_idx 0, 1, 2, 3, each 2 cycles after request; new_buf_req never asserted; ref_vld/ref_buf_numbr match each idx.
- Hit: request 0x33 -> acc_ack 2 cycles later, acc_hit=1, acc_idx=2, ref_buf_numbr=2, no tag write.
- Eviction: store full, request 0x55, model returns buf_num_replc=1 -> new_buf_req high exactly 1 cycle, ack acc_hit=0 acc_idx=1 three cycles after the accepting edge; then 0x22 misses and 0x55 hits idx 1.
- Flush+request: flush=1 and acc_req=1 tag 0x44 in the same IDLE cycle -> ack acc_hit=0, acc_idx=0; a subsequent 0x11 fills idx 1.
- Reset in WAIT: rst pulse during WAIT -> no acc_ack ever for that request, valid all 0, acc_rdy=1 after release; next request 0x55 fills idx 0.
